// File: rtl/data_memory_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : data_memory_ctrl                                           |
// | Description : Word-addressed data memory for the MIPS MEM stage with     |
// |               byte-lane writes, req/ready handshake, configurable wait   |
// |               states, out-of-range error reporting and an optional       |
// |               post-reset initialisation sweep (DMEM_RESET_INIT_EN).      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module data_memory_ctrl #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 64,
    parameter int ADDR_W      = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W/8-1:0]   byte_en,
    input  logic [DATA_W-1:0]     wdata,
    output logic                  ready,
    output logic                  rvalid,
    output logic [DATA_W-1:0]     rdata,
    output logic                  err,
    output logic                  busy
);

    localparam int c_LANES = DATA_W / 8;
    localparam int c_OFF_W = $clog2(c_LANES);
    localparam int c_IDX_W = $clog2(DEPTH);
    localparam int c_LIM_W = ADDR_W + 1;
    // First byte address past the end of storage; one extra bit so it never wraps
    localparam logic [c_LIM_W-1:0] c_LIMIT = c_LIM_W'(DEPTH * c_LANES);
    localparam logic [3:0]         c_WAIT  = 4'(WAIT_STATES);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;
`ifdef DMEM_RESET_INIT_EN
    localparam logic [1:0] c_ST_INIT = 2'd3;
    localparam logic [1:0] c_ST_RST  = c_ST_INIT;
`else
    localparam logic [1:0] c_ST_RST  = c_ST_IDLE;
`endif

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [1:0]         r_state;
    logic [3:0]         r_cnt;
    logic [c_IDX_W-1:0] r_idx;
    logic               r_oor;
`ifdef DMEM_RESET_INIT_EN
    logic [c_IDX_W-1:0] r_ptr;
    logic               r_busy;
`endif

    logic [c_IDX_W-1:0] w_idx;
    logic               w_oor;
    logic               w_accept;
    logic [DATA_W-1:0]  w_cur;
    logic [DATA_W-1:0]  w_merged;
    logic               w_mem_we;
    logic [c_IDX_W-1:0] w_mem_idx;
    logic [DATA_W-1:0]  w_mem_wdata;

    assign w_idx    = addr[c_OFF_W +: c_IDX_W];
    assign w_oor    = {1'b0, addr} >= c_LIMIT;
    assign w_accept = (r_state == c_ST_IDLE) && req;
    // In IDLE the live address is looked up (for merging); later the captured one
    assign w_cur    = r_mem[(r_state == c_ST_IDLE) ? w_idx : r_idx];

    // Per-lane merge of the incoming write data over the currently stored word
    genvar g;
    generate
        for (g = 0; g < c_LANES; g++) begin : g_lane
            assign w_merged[8*g +: 8] = byte_en[g] ? wdata[8*g +: 8] : w_cur[8*g +: 8];
        end
    endgenerate

`ifdef DMEM_RESET_INIT_EN
    assign busy = r_busy;
`else
    assign busy = 1'b0;
`endif

    // Single write port: accepted in-range writes, or the init sweep
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_idx   = w_idx;
        w_mem_wdata = w_merged;
        if (w_accept && we && !w_oor) begin
            w_mem_we = !rst;
        end
`ifdef DMEM_RESET_INIT_EN
        if (r_state == c_ST_INIT) begin
            w_mem_we    = !rst;
            w_mem_idx   = r_ptr;
            w_mem_wdata = DATA_W'(r_ptr);
        end
`endif
    end

    // Storage array; not reset, contents are owned by the sweep or by writes
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_idx] <= w_mem_wdata;
        end
    end

    // Control FSM with registered response outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_RST;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_oor   <= 1'b0;
            ready   <= 1'b0;
            rvalid  <= 1'b0;
            err     <= 1'b0;
            rdata   <= '0;
`ifdef DMEM_RESET_INIT_EN
            r_ptr   <= '0;
            r_busy  <= 1'b1;
`endif
        end else begin
            ready  <= 1'b0;
            rvalid <= 1'b0;
            err    <= 1'b0;
            case (r_state)
`ifdef DMEM_RESET_INIT_EN
                c_ST_INIT: begin
                    r_ptr <= r_ptr + c_IDX_W'(1);
                    if (r_ptr == c_IDX_W'(DEPTH - 1)) begin
                        r_state <= c_ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
`endif
                c_ST_IDLE: begin
                    if (req) begin
                        r_idx <= w_idx;
                        r_oor <= w_oor;
                        r_cnt <= c_WAIT;
                        if (WAIT_STATES == 0) begin
                            // Entering RESP on the commit edge: memory still
                            // holds the old word, so present the merge directly
                            r_state <= c_ST_RESP;
                            rdata   <= w_oor ? '0 : (we ? w_merged : w_cur);
                        end else begin
                            r_state <= c_ST_WAIT;
                        end
                    end
                end
                c_ST_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        // Writes committed at acceptance, so this is the merged word
                        r_state <= c_ST_RESP;
                        rdata   <= r_oor ? '0 : w_cur;
                    end
                end
                c_ST_RESP: begin
                    ready   <= 1'b1;
                    rvalid  <= !r_oor;
                    err     <= r_oor;
                    r_state <= c_ST_IDLE;
                end
                default: r_state <= c_ST_RST;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_memory_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_data_memory_ctrl                                        |
// | Description : Self-checking bench for data_memory_ctrl against a         |
// |               byte-granular reference memory model.                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_data_memory_ctrl;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 32;
    localparam int WS     = 1;
    localparam int LANES  = DATA_W / 8;
    localparam int c_LAT  = WS + 2;
    localparam int c_TMO  = 300;
`ifdef DMEM_RESET_INIT_EN
    localparam int   c_INIT_CYC = DEPTH;
    localparam logic c_BUSY_RST = 1'b1;
`else
    localparam int   c_INIT_CYC = 0;
    localparam logic c_BUSY_RST = 1'b0;
`endif

    logic              clk     = 1'b0;
    logic              rst     = 1'b1;
    logic              req     = 1'b0;
    logic              we      = 1'b0;
    logic [ADDR_W-1:0] addr    = '0;
    logic [LANES-1:0]  byte_en = '0;
    logic [DATA_W-1:0] wdata   = '0;
    logic              ready;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    // Reference memory: word contents plus per-byte "known" flags
    logic [DATA_W-1:0] m_data [DEPTH];
    logic [LANES-1:0]  m_val  [DEPTH];

    data_memory_ctrl #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .WAIT_STATES(WS)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr),
        .byte_en(byte_en), .wdata(wdata), .ready(ready), .rvalid(rvalid),
        .rdata(rdata), .err(err), .busy(busy)
    );

    // Free-running clock
    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] lane_mask(input logic [LANES-1:0] v);
        logic [DATA_W-1:0] m;
        for (int b = 0; b < LANES; b++) m[8*b +: 8] = {8{v[b]}};
        return m;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) begin
`ifdef DMEM_RESET_INIT_EN
            m_data[i] = DATA_W'(i);
            m_val[i]  = '1;
`else
            m_data[i] = '0;
            m_val[i]  = '0;
`endif
        end
    endfunction

    // Applies one access to the model and returns the expected response
    function automatic void model_access(input logic iwe, input logic [ADDR_W-1:0] a,
                                         input logic [LANES-1:0] be, input logic [DATA_W-1:0] wd,
                                         output logic [DATA_W-1:0] e_data,
                                         output logic [DATA_W-1:0] e_mask, output logic e_err);
        int w;
        e_err  = (a >= ADDR_W'(DEPTH * LANES));
        e_data = '0;
        e_mask = '1;
        if (!e_err) begin
            w = int'(a / LANES);
            if (iwe) begin
                for (int b = 0; b < LANES; b++) begin
                    if (be[b]) begin
                        m_data[w][8*b +: 8] = wd[8*b +: 8];
                        m_val[w][b] = 1'b1;
                    end
                end
            end
            e_data = m_data[w];
            e_mask = lane_mask(m_val[w]);
        end
    endfunction

    // Drives one request, waits for ready and reports what came back
    task automatic xfer(input logic iwe, input logic [ADDR_W-1:0] a, input logic [LANES-1:0] be,
                        input logic [DATA_W-1:0] wd, output logic [DATA_W-1:0] got_rd,
                        output logic got_rv, output logic got_err, output int lat, output logic tail);
        @(negedge clk);
        we = iwe; addr = a; byte_en = be; wdata = wd; req = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!ready && lat < c_TMO);
        got_rd = rdata; got_rv = rvalid; got_err = err;
        req = 1'b0;
        @(negedge clk);
        tail = ready;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", ready); end
        checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%b exp=0", rvalid); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++; if (rdata !== '0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        checks++; if (busy !== c_BUSY_RST) begin failures++; $display("FAIL reset_busy got=%b exp=%b", busy, c_BUSY_RST); end
    endtask

    task automatic test_init();
        int lat, busy_cnt;
        @(negedge clk);
        rst = 1'b0; req = 1'b1; we = 1'b0; addr = 32'h14; byte_en = '0; wdata = '0;
        lat = 0;
        busy_cnt = busy ? 1 : 0;
        do begin
            @(negedge clk);
            lat++;
            if (busy) busy_cnt++;
        end while (!ready && lat < c_TMO);
        checks++; if (lat !== c_INIT_CYC + c_LAT) begin failures++; $display("FAIL init_latency got=%0d exp=%0d", lat, c_INIT_CYC + c_LAT); end
        checks++; if (busy_cnt !== c_INIT_CYC) begin failures++; $display("FAIL init_busy_cycles got=%0d exp=%0d", busy_cnt, c_INIT_CYC); end
        checks++; if ({rvalid, err} !== 2'b10) begin failures++; $display("FAIL init_flags got=%b%b exp=10", rvalid, err); end
`ifdef DMEM_RESET_INIT_EN
        checks++; if (rdata !== 32'd5) begin failures++; $display("FAIL init_rdata got=%h exp=00000005", rdata); end
`endif
        req = 1'b0;
        @(negedge clk);
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL init_ready_width got=%b exp=0", ready); end
    endtask

    task automatic test_byte_lane();
        logic [DATA_W-1:0] rd, e_d, e_m;
        logic rv, er, e_e, tl;
        int lat;
        xfer(1'b1, 32'h08, 4'hF, 32'h2, rd, rv, er, lat, tl);
        model_access(1'b1, 32'h08, 4'hF, 32'h2, e_d, e_m, e_e);
        checks++; if (rd !== 32'h2) begin failures++; $display("FAIL lane_base got=%h exp=00000002", rd); end
        xfer(1'b1, 32'h08, 4'b0101, 32'hAABBCCDD, rd, rv, er, lat, tl);
        model_access(1'b1, 32'h08, 4'b0101, 32'hAABBCCDD, e_d, e_m, e_e);
        checks++; if (rd !== e_d) begin failures++; $display("FAIL lane_write_resp got=%h exp=%h", rd, e_d); end
        checks++; if (lat !== c_LAT) begin failures++; $display("FAIL lane_write_lat got=%0d exp=%0d", lat, c_LAT); end
        xfer(1'b0, 32'h0B, 4'h0, 32'h0, rd, rv, er, lat, tl);
        model_access(1'b0, 32'h0B, 4'h0, 32'h0, e_d, e_m, e_e);
        checks++; if (rd !== 32'h00BB00DD) begin failures++; $display("FAIL lane_readback got=%h exp=00bb00dd", rd); end
        checks++; if ({rv, er} !== 2'b10) begin failures++; $display("FAIL lane_read_flags got=%b%b exp=10", rv, er); end
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] rd, rd1, rd2, e_d, e_m;
        logic rv, er, e_e, tl;
        int lat, lat1, lat2;
        xfer(1'b1, 32'h04, 4'hF, 32'd1, rd, rv, er, lat, tl);
        model_access(1'b1, 32'h04, 4'hF, 32'd1, e_d, e_m, e_e);
        xfer(1'b1, 32'h0C, 4'hF, 32'd3, rd, rv, er, lat, tl);
        model_access(1'b1, 32'h0C, 4'hF, 32'd3, e_d, e_m, e_e);
        @(negedge clk);
        we = 1'b0; addr = 32'h04; req = 1'b1;
        lat1 = 0;
        do begin @(negedge clk); lat1++; end while (!ready && lat1 < c_TMO);
        rd1 = rdata;
        addr = 32'h0C;
        lat2 = 0;
        do begin @(negedge clk); lat2++; end while (!ready && lat2 < c_TMO);
        rd2 = rdata;
        req = 1'b0;
        @(negedge clk);
        checks++; if (lat1 !== c_LAT) begin failures++; $display("FAIL b2b_first_lat got=%0d exp=%0d", lat1, c_LAT); end
        checks++; if (lat2 !== c_LAT) begin failures++; $display("FAIL b2b_spacing got=%0d exp=%0d", lat2, c_LAT); end
        checks++; if (rd1 !== 32'd1) begin failures++; $display("FAIL b2b_rdata1 got=%h exp=00000001", rd1); end
        checks++; if (rd2 !== 32'd3) begin failures++; $display("FAIL b2b_rdata2 got=%h exp=00000003", rd2); end
    endtask

    task automatic test_out_of_range();
        logic [DATA_W-1:0] rd, e_d, e_m, wd;
        logic rv, er, e_e, tl;
        int lat;
        xfer(1'b0, 32'h100, 4'h0, 32'h0, rd, rv, er, lat, tl);
        checks++; if ({rv, er, rd} !== {2'b01, 32'h0}) begin failures++; $display("FAIL oor_read got=rv%b err%b %h exp=rv0 err1 00000000", rv, er, rd); end
        for (int i = 0; i < DEPTH; i++) begin
            wd = $urandom;
            xfer(1'b1, ADDR_W'(i * LANES), 4'hF, wd, rd, rv, er, lat, tl);
            model_access(1'b1, ADDR_W'(i * LANES), 4'hF, wd, e_d, e_m, e_e);
            checks++; if (rd !== e_d) begin failures++; $display("FAIL oor_fill[%0d] got=%h exp=%h", i, rd, e_d); end
        end
        xfer(1'b1, 32'h100, 4'hF, 32'hDEADBEEF, rd, rv, er, lat, tl);
        checks++; if ({rv, er, rd} !== {2'b01, 32'h0}) begin failures++; $display("FAIL oor_write got=rv%b err%b %h exp=rv0 err1 00000000", rv, er, rd); end
        xfer(1'b1, 32'hFFFF_FFFC, 4'hF, 32'h12345678, rd, rv, er, lat, tl);
        checks++; if (er !== 1'b1) begin failures++; $display("FAIL oor_high_write got=%b exp=1", er); end
        for (int i = 0; i < DEPTH; i++) begin
            xfer(1'b0, ADDR_W'(i * LANES), 4'h0, 32'h0, rd, rv, er, lat, tl);
            model_access(1'b0, ADDR_W'(i * LANES), 4'h0, 32'h0, e_d, e_m, e_e);
            checks++; if (rd !== e_d) begin failures++; $display("FAIL oor_unchanged[%0d] got=%h exp=%h", i, rd, e_d); end
        end
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] rd, e_d, e_m, wd;
        logic [ADDR_W-1:0] a;
        logic [LANES-1:0] be;
        logic rv, er, e_e, tl, iwe;
        int lat;
        for (int n = 0; n < 60; n++) begin
            iwe = 1'($urandom_range(0, 1));
            a   = ($urandom_range(0, 4) == 0) ? ADDR_W'($urandom_range(256, 32'hFFFF_FFFF))
                                              : ADDR_W'($urandom_range(0, 255));
            be  = 4'($urandom);
            wd  = $urandom;
            xfer(iwe, a, be, wd, rd, rv, er, lat, tl);
            model_access(iwe, a, be, wd, e_d, e_m, e_e);
            checks++; if (lat !== c_LAT) begin failures++; $display("FAIL rand_lat[%0d] got=%0d exp=%0d", n, lat, c_LAT); end
            checks++; if ({rv, er} !== {!e_e, e_e}) begin failures++; $display("FAIL rand_flags[%0d] got=%b%b exp=%b%b", n, rv, er, !e_e, e_e); end
            checks++; if ((rd & e_m) !== (e_d & e_m)) begin failures++; $display("FAIL rand_data[%0d] addr=%h got=%h exp=%h mask=%h", n, a, rd, e_d, e_m); end
            checks++; if (tl !== 1'b0) begin failures++; $display("FAIL rand_ready_width[%0d] got=%b exp=0", n, tl); end
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        int lat;
        @(negedge clk);
        we = 1'b0; addr = 32'h04; req = 1'b1;
        @(negedge clk);
        rst = 1'b1; req = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (ready) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL mid_ready_seen got=%b exp=0", seen); end
        checks++; if (busy !== c_BUSY_RST) begin failures++; $display("FAIL mid_busy got=%b exp=%b", busy, c_BUSY_RST); end
        model_reset();
        rst = 1'b0; req = 1'b1; we = 1'b0; addr = 32'h0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!ready && lat < c_TMO);
        checks++; if (lat !== c_INIT_CYC + c_LAT) begin failures++; $display("FAIL mid_restart_lat got=%0d exp=%0d", lat, c_INIT_CYC + c_LAT); end
        checks++; if ({rvalid, err} !== 2'b10) begin failures++; $display("FAIL mid_flags got=%b%b exp=10", rvalid, err); end
`ifdef DMEM_RESET_INIT_EN
        checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL mid_rdata got=%h exp=00000000", rdata); end
`endif
        req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_init();
        test_byte_lane();
        test_back_to_back();
        test_out_of_range();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
